// File: rtl/ex_mdu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ex_mdu_ctrl_pkg
// Shared definitions for the EX-stage multiply/divide sequencer: operation
// bus type and codes, FSM state encodings and the default MDU widths.
// ---------------------------------------------------------------------------
package ex_mdu_ctrl_pkg;

  // Default MDU widths; the counter must be able to hold MDU_DATA_W-1.
  localparam int MDU_DATA_W = 32;
  localparam int MDU_CNT_W  = 5;

  // Operation bus and codes.
  typedef logic [1:0] mdu_op_bus_t;

  localparam mdu_op_bus_t MDU_OP_MUL   = 2'b00;
  localparam mdu_op_bus_t MDU_OP_MULHU = 2'b01;
  localparam mdu_op_bus_t MDU_OP_DIVU  = 2'b10;
  localparam mdu_op_bus_t MDU_OP_REMU  = 2'b11;

  // Sequencer state encodings.
  localparam logic [1:0] MDU_ST_IDLE = 2'd0;
  localparam logic [1:0] MDU_ST_BUSY = 2'd1;
  localparam logic [1:0] MDU_ST_DONE = 2'd2;

  // DIVU/REMU share the restoring-divide datapath.
  function automatic logic mdu_op_is_div(input mdu_op_bus_t op);
    return op[1];
  endfunction

  // MULHU/REMU return the upper half of the shared 2*W register.
  function automatic logic mdu_op_takes_high(input mdu_op_bus_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// ---------------------------------------------------------------------------
// mdu_step
// One combinational iteration of the shared shift/add-subtract datapath.
//   acc      : current 2*W register ({rem,quo} when dividing)
//   mcand    : multiplicand (unused when dividing)
//   operand  : multiplier (multiply) or divisor (divide)
//   cnt      : iteration index, selects the multiplier bit MSB-first
//   div_mode : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_next : register value after this iteration
// ---------------------------------------------------------------------------
module mdu_step
  import ex_mdu_ctrl_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W,
  parameter int CNT_W  = MDU_CNT_W
) (
  input  logic [2*DATA_W-1:0] acc,
  input  logic [DATA_W-1:0]   mcand,
  input  logic [DATA_W-1:0]   operand,
  input  logic [CNT_W-1:0]    cnt,
  input  logic                div_mode,
  output logic [2*DATA_W-1:0] acc_next
);

  logic [2*DATA_W-1:0] shifted_s;
  logic [CNT_W-1:0]    bit_idx_s;
  logic                mul_bit_s;
  logic [DATA_W:0]     part_s;
  logic                fits_s;
  logic [DATA_W-1:0]   diff_s;

  // Single multiply or divide iteration.
  always_comb begin
    shifted_s = {acc[2*DATA_W-2:0], 1'b0};
    bit_idx_s = CNT_W'(DATA_W - 1) - cnt;
    mul_bit_s = operand[bit_idx_s];
    // The shifted remainder can reach W+1 bits (divisor above 2^(W-1)),
    // so compare with the bit that falls out of the top included.
    part_s    = acc[2*DATA_W-1:DATA_W-1];
    fits_s    = (part_s >= {1'b0, operand});
    // When fits_s holds the difference is below the divisor, so W bits suffice.
    diff_s    = part_s[DATA_W-1:0] - operand;
    acc_next  = shifted_s;
    if (div_mode) begin
      if (fits_s) begin
        acc_next = {diff_s, shifted_s[DATA_W-1:1], 1'b1};
      end else begin
        acc_next = shifted_s;
      end
    end else begin
      if (mul_bit_s) begin
        acc_next = shifted_s + {{DATA_W{1'b0}}, mcand};
      end else begin
        acc_next = shifted_s;
      end
    end
  end

endmodule

// File: rtl/ex_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// ex_mdu_ctrl
// Multicycle unsigned multiply/divide sequencer in the EX stage. Accepts an
// operation from ID/EX, stalls the front of the pipeline while iterating
// mdu_step DATA_W times, then presents a registered result for one DONE
// cycle so EX/MEM can capture it in place of the ALU result.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   start     : request, honoured only in IDLE with flush low
//   op        : MUL / MULHU / DIVU / REMU
//   in_0      : multiplicand / dividend
//   in_1      : multiplier / divisor
//   flush     : abort the current operation
//   mdu_stall : hold IF/ID/EX registers
//   busy      : state is BUSY
//   done      : one-cycle result-valid strobe
//   out       : registered result
//   dz        : divide-by-zero flag of the last completed operation
// ---------------------------------------------------------------------------
module ex_mdu_ctrl
  import ex_mdu_ctrl_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W,
  parameter int CNT_W  = MDU_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic              flush,
  output logic              mdu_stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out,
  output logic              dz
);

  logic [1:0]          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [1:0]          op_r;
  logic [DATA_W-1:0]   mcand_r;
  logic [DATA_W-1:0]   operand_r;
  logic [2*DATA_W-1:0] acc_r;
  logic [DATA_W-1:0]   out_r;
  logic                dz_r;

  logic                accept_s;
  logic                dz_fast_s;
  logic [DATA_W-1:0]   dz_value_s;
  logic [2*DATA_W-1:0] acc_next_s;
  logic [DATA_W-1:0]   result_s;
  logic                last_iter_s;

  mdu_step #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_step (
    .acc      (acc_r),
    .mcand    (mcand_r),
    .operand  (operand_r),
    .cnt      (cnt_r),
    .div_mode (mdu_op_is_div(op_r)),
    .acc_next (acc_next_s)
  );

  // Accept decode, divide-by-zero fast path and final-result selection.
  always_comb begin
    accept_s    = (state_r == MDU_ST_IDLE) && start && !flush;
    dz_fast_s   = accept_s && mdu_op_is_div(op) && (in_1 == {DATA_W{1'b0}});
    last_iter_s = (cnt_r == CNT_W'(DATA_W - 1));
    if (op == MDU_OP_REMU) begin
      dz_value_s = in_0;
    end else begin
      dz_value_s = {DATA_W{1'b1}};
    end
    // {rem,quo} sits in the same 2*W register as the product, so the
    // high/low selection is common to both operation families.
    if (mdu_op_takes_high(op_r)) begin
      result_s = acc_next_s[2*DATA_W-1:DATA_W];
    end else begin
      result_s = acc_next_s[DATA_W-1:0];
    end
  end

  // Sequencer FSM, iteration counter, datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= MDU_ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      op_r      <= MDU_OP_MUL;
      mcand_r   <= {DATA_W{1'b0}};
      operand_r <= {DATA_W{1'b0}};
      acc_r     <= {(2*DATA_W){1'b0}};
      out_r     <= {DATA_W{1'b0}};
      dz_r      <= 1'b0;
    end else begin
      case (state_r)
        MDU_ST_IDLE: begin
          if (accept_s) begin
            op_r      <= op;
            mcand_r   <= in_0;
            operand_r <= in_1;
            cnt_r     <= {CNT_W{1'b0}};
            if (mdu_op_is_div(op)) begin
              acc_r <= {{DATA_W{1'b0}}, in_0};
            end else begin
              acc_r <= {(2*DATA_W){1'b0}};
            end
            if (dz_fast_s) begin
              out_r   <= dz_value_s;
              dz_r    <= 1'b1;
              state_r <= MDU_ST_DONE;
            end else begin
              state_r <= MDU_ST_BUSY;
            end
          end else begin
            state_r <= MDU_ST_IDLE;
          end
        end
        MDU_ST_BUSY: begin
          if (flush) begin
            state_r <= MDU_ST_IDLE;
          end else begin
            acc_r <= acc_next_s;
            if (last_iter_s) begin
              out_r   <= result_s;
              dz_r    <= 1'b0;
              state_r <= MDU_ST_DONE;
            end else begin
              cnt_r   <= cnt_r + CNT_W'(1);
              state_r <= MDU_ST_BUSY;
            end
          end
        end
        MDU_ST_DONE: begin
          state_r <= MDU_ST_IDLE;
        end
        default: begin
          state_r <= MDU_ST_IDLE;
        end
      endcase
    end
  end

  // Output decode; the stall is combinational from start so ID/EX holds on
  // the accepting edge, and drops in DONE so EX/MEM captures the result.
  always_comb begin
    mdu_stall = accept_s || (state_r == MDU_ST_BUSY);
    busy      = (state_r == MDU_ST_BUSY);
    done      = (state_r == MDU_ST_DONE);
    out       = out_r;
    dz        = dz_r;
  end

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_mdu_ctrl
// Self-checking bench for ex_mdu_ctrl: directed cases plus randomized
// operations compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_ex_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in_0;
  logic [31:0] in_1;
  logic        flush;
  logic        mdu_stall;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        dz;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_out = 32'd0;
  logic        exp_dz  = 1'b0;

  ex_mdu_ctrl #(
    .DATA_W (32),
    .CNT_W  (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .in_0      (in_0),
    .in_1      (in_1),
    .flush     (flush),
    .mdu_stall (mdu_stall),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0h, required %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: plain unsigned arithmetic on the operands.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic z);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    z = 1'b0;
    case (o)
      2'd0: r = p[31:0];
      2'd1: r = p[63:32];
      2'd2: begin
        if (b == 32'd0) begin r = 32'hFFFF_FFFF; z = 1'b1; end
        else r = a / b;
      end
      default: begin
        if (b == 32'd0) begin r = a; z = 1'b1; end
        else r = a % b;
      end
    endcase
  endfunction

  // Issue one op just after a rising edge and follow it for 40 cycles.
  // flush_at > 0 pulses flush in that cycle; poke re-asserts start mid-BUSY.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input bit poke);
    logic [31:0] res;
    logic        z;
    int          dc;
    bit          flushed;
    bit          act;
    int          done_cyc = 0;
    int          done_extra = 0;
    int          bad_stall = 0;
    int          bad_busy = 0;
    logic [31:0] out_at_done = 32'd0;

    model(o, a, b, res, z);
    dc      = z ? 1 : 33;
    flushed = (flush_at > 0) && (flush_at < dc);

    start = 1'b1; op = o; in_0 = a; in_1 = b;
    @(negedge clk);
    check("stall_accept", {63'd0, mdu_stall}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); in_0 = $urandom; in_1 = $urandom;

    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      act = (cyc < dc) && (!flushed || cyc <= flush_at);
      if (mdu_stall !== act) bad_stall++;
      if (busy !== act) bad_busy++;
      if (done === 1'b1) begin
        if (done_cyc == 0) done_cyc = cyc;
        else done_extra++;
        out_at_done = out;
      end
      if (poke && !z && cyc == 5) begin
        start = 1'b1; op = 2'($urandom); in_0 = $urandom; in_1 = $urandom;
      end
      if (cyc == 6) start = 1'b0;
      flush = (cyc == flush_at);
    end
    flush = 1'b0;

    if (!flushed) begin
      exp_out = res;
      exp_dz  = z;
      check("out_at_done", {32'd0, out_at_done}, {32'd0, res});
    end
    check("stall_seq", bad_stall, 0);
    check("busy_seq", bad_busy, 0);
    check("done_cycle", done_cyc, flushed ? 0 : dc);
    check("done_extra", done_extra, 0);
    check("out_hold", {32'd0, out}, {32'd0, exp_out});
    check("dz", {63'd0, dz}, {63'd0, exp_dz});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          fa;
    bit          pk;

    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; in_0 = 32'd0; in_1 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", {32'd0, out}, 64'd0);
    check("rst_flags", {60'd0, busy, done, dz, mdu_stall}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases from the plan.
    run_op(2'd0, 32'h0001_0003, 32'h0002_0005, 0, 1'b0);
    check("mul_spec", {32'd0, out}, 64'h0000_0000_000B_000F);
    run_op(2'd1, 32'h0001_0003, 32'h0002_0005, 0, 1'b0);
    check("mulhu_spec", {32'd0, out}, 64'h2);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check("mulhu_max", {32'd0, out}, 64'hFFFF_FFFE);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check("mul_max", {32'd0, out}, 64'h1);
    run_op(2'd2, 32'd100, 32'd7, 0, 1'b1);
    check("divu_spec", {32'd0, out}, 64'hE);
    run_op(2'd3, 32'd100, 32'd7, 0, 1'b0);
    check("remu_spec", {31'd0, dz, out}, 64'h2);
    run_op(2'd2, 32'h1234_5678, 32'd0, 0, 1'b0);
    check("divu_dz", {31'd0, dz, out}, 64'h1_FFFF_FFFF);
    run_op(2'd3, 32'h1234_5678, 32'd0, 0, 1'b0);
    check("remu_dz", {31'd0, dz, out}, 64'h1_1234_5678);
    run_op(2'd0, 32'h0001_0003, 32'h0002_0005, 10, 1'b0);
    run_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0001, 0, 1'b0);

    // Flush and start in the same IDLE cycle: nothing accepted.
    start = 1'b1; flush = 1'b1; op = 2'd0; in_0 = 32'd3; in_1 = 32'd3;
    @(negedge clk);
    check("flush_idle_stall", {63'd0, mdu_stall}, 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("flush_idle_busy", {63'd0, busy}, 64'd0);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      fa = 0;
      if (!(ro[1] && rb == 32'd0) && $urandom_range(0, 4) == 0) fa = $urandom_range(1, 32);
      pk = (fa == 0) && ($urandom_range(0, 1) == 1);
      run_op(ro, ra, rb, fa, pk);
    end

    // Asynchronous reset in the middle of BUSY.
    start = 1'b1; op = 2'd1; in_0 = 32'hDEAD_BEEF; in_1 = 32'h1234_5679;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_out", {32'd0, out}, 64'd0);
    check("arst_flags", {60'd0, busy, done, dz, mdu_stall}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_out = 32'd0;
    exp_dz  = 1'b0;
    @(posedge clk);
    #1;
    run_op(2'd3, 32'hCAFE_F00D, 32'd1000, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
